// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that fills the instruction memory from a
// length-prefixed, XOR-checksummed byte stream and holds the core in reset
// until a good image has arrived.
module imem_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // One extra bit so a word index equal to DEPTH never wraps.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state_reg, state_next;
    logic [15:0]     len_reg, len_next;
    logic [1:0]      cnt_reg, cnt_next;
    logic [WW-1:0]   word_reg, word_next;
    logic [7:0]      acc_reg, acc_next;
    logic [23:0]     asm_reg, asm_next;
    logic            we_reg, we_next;
    logic [WW-1:0]   addr_reg, addr_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic            hold_reg, hold_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            error_reg, error_next;

    logic            accept;
    logic [15:0]     len_full;

    // rx_ready depends only on the state, never on rx_valid.
    assign rx_ready  = (state_reg == S_LEN) || (state_reg == S_DATA) || (state_reg == S_CSUM);
    assign accept    = rx_valid && rx_ready;
    assign len_full  = {rx_data, len_reg[7:0]};

    assign mem_we    = we_reg;
    assign mem_addr  = {{(30 - WW){1'b0}}, addr_reg, 2'b00};
    assign mem_wdata = wdata_reg;
    assign cpu_hold  = hold_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign error     = error_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath, write-port and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg   <= '0;
            cnt_reg   <= '0;
            word_reg  <= '0;
            acc_reg   <= '0;
            asm_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            hold_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
            acc_reg   <= acc_next;
            asm_reg   <= asm_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            hold_reg  <= hold_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            error_reg <= error_next;
        end
    end

    // Next-state and next-register logic; everything holds unless changed,
    // except the write strobe which is a single-cycle pulse.
    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        acc_next   = acc_reg;
        asm_next   = asm_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        hold_next  = hold_reg;
        busy_next  = busy_reg;
        done_next  = done_reg;
        error_next = error_reg;

        case (state_reg)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_next = S_LEN;
                    done_next  = 1'b0;
                    error_next = 1'b0;
                    busy_next  = 1'b1;
                    hold_next  = 1'b1;
                    cnt_next   = '0;
                    word_next  = '0;
                    acc_next   = '0;
                    len_next   = '0;
                end
            end

            S_LEN: begin
                if (accept) begin
                    if (!cnt_reg[0]) begin
                        len_next[7:0] = rx_data;
                        cnt_next      = 2'd1;
                    end else begin
                        len_next[15:8] = rx_data;
                        cnt_next       = 2'd0;
                        if ({1'b0, len_full} > 17'(DEPTH)) begin
                            state_next = S_ERR;
                            error_next = 1'b1;
                            busy_next  = 1'b0;
                        end else if (len_full == 16'd0) begin
                            state_next = S_CSUM;
                        end else begin
                            state_next = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    acc_next = acc_reg ^ rx_data;
                    cnt_next = cnt_reg + 2'd1;
                    case (cnt_reg)
                        2'd0: asm_next[7:0]   = rx_data;
                        2'd1: asm_next[15:8]  = rx_data;
                        2'd2: asm_next[23:16] = rx_data;
                        default: begin
                            // Fourth byte completes the word: write it directly
                            // from the incoming byte and the three held lanes.
                            we_next    = 1'b1;
                            addr_next  = word_reg;
                            wdata_next = {rx_data, asm_reg};
                            word_next  = word_reg + 1'b1;
                            if (17'(word_reg) + 17'd1 == {1'b0, len_reg}) begin
                                state_next = S_CSUM;
                            end
                        end
                    endcase
                end
            end

            S_CSUM: begin
                if (accept) begin
                    busy_next = 1'b0;
                    if (rx_data == acc_reg) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                        hold_next  = 1'b0;
                    end else begin
                        state_next = S_ERR;
                        error_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven image sessions plus hand-written corner cases
// (oversize length, reset mid-load, start during a session). Expected memory
// writes go into a scoreboard queue when the completing byte is driven and
// are popped by a monitor whenever mem_we is seen.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    imem_loader #(.DEPTH(256)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] tb_mem [0:255];

    typedef struct packed {
        logic [15:0]      n;
        logic [3:0][31:0] words;
        logic [7:0]       csum;
        logic [1:0]       max_gap;
        logic             exp_done;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                         mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr 0x%08h data 0x%08h expected addr 0x%08h data 0x%08h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end else begin
                    $display("write addr 0x%08h data 0x%08h", mem_addr, mem_wdata);
                end
            end
            tb_mem[mem_addr[9:2]] = mem_wdata;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited = 0;
        rx_valid = 1'b0;
        repeat (gap) begin
            rx_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got rx_ready 0 for 20 cycles expected 1 (byte 0x%02h)", b);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_start();
        pulse_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_err_clr", 32'(error), 32'd0);
        chk("start_ready", 32'(rx_ready), 32'd1);
    endtask

    // poke: pulse start inside the session, which must be ignored.
    task automatic run_image(input vec_t v, input int idx, input bit poke);
        do_start();
        send_byte(v.n[7:0], $urandom_range(0, int'(v.max_gap)));
        send_byte(v.n[15:8], $urandom_range(0, int'(v.max_gap)));
        for (int w = 0; w < int'(v.n); w++) begin
            for (int b = 0; b < 4; b++) begin
                if (poke && b == 2) begin
                    pulse_start();
                    chk("start_ignored_busy", 32'(busy), 32'd1);
                    chk("start_ignored_ready", 32'(rx_ready), 32'd1);
                end
                if (b == 3) exp_q.push_back('{addr: 32'(w * 4), data: v.words[w]});
                send_byte(v.words[w][8*b +: 8], $urandom_range(0, int'(v.max_gap)));
            end
        end
        send_byte(v.csum, $urandom_range(0, int'(v.max_gap)));
        chk("end_done", 32'(done), 32'(v.exp_done));
        chk("end_error", 32'(error), 32'(!v.exp_done));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_hold", 32'(cpu_hold), 32'(!v.exp_done));
        chk("end_ready", 32'(rx_ready), 32'd0);
        chk("end_queue_empty", 32'(exp_q.size()), 32'd0);
        if (v.n != 16'd0) begin
            chk("held_addr", mem_addr, 32'(4 * (int'(v.n) - 1)));
            chk("held_wdata", mem_wdata, v.words[int'(v.n) - 1]);
        end
        $display("session %0d: N=%0d csum 0x%02h done=%0b error=%0b", idx, v.n, v.csum, done, error);
    endtask

    vec_t vecs [6];
    vec_t v3;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // XOR of 13 00 00 00 93 00 10 00 is 0x90; 0x91 is one bit off.
        vecs[0] = '{n: 16'd2, words: {32'h0, 32'h0, 32'h00100093, 32'h00000013},
                    csum: 8'h90, max_gap: 2'd0, exp_done: 1'b1};
        vecs[1] = '{n: 16'd2, words: {32'h0, 32'h0, 32'h00100093, 32'h00000013},
                    csum: 8'h91, max_gap: 2'd0, exp_done: 1'b0};
        vecs[2] = '{n: 16'd2, words: {32'h0, 32'h0, 32'h00100093, 32'h00000013},
                    csum: 8'h90, max_gap: 2'd0, exp_done: 1'b1};
        vecs[3] = '{n: 16'd0, words: '0, csum: 8'h00, max_gap: 2'd0, exp_done: 1'b1};
        vecs[4] = '{n: 16'd0, words: '0, csum: 8'h5A, max_gap: 2'd0, exp_done: 1'b0};
        vecs[5] = '{n: 16'd4,
                    words: {32'hA5A55A5A, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF},
                    csum: 8'h22, max_gap: 2'd3, exp_done: 1'b1};
        // Three words, XOR 0xA2.
        v3 = '{n: 16'd3, words: {32'h0, 32'h00200113, 32'h00100093, 32'h00000013},
               csum: 8'hA2, max_gap: 2'd1, exp_done: 1'b1};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rx_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst_n = 1'b1;

        // Bytes offered in IDLE are not consumed.
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("idle_ready", 32'(rx_ready), 32'd0);
        end
        rx_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_image(vecs[i], i, 1'b0);
            if (i == 0) begin
                chk("readback_pc0", tb_mem[0], 32'h00000013);
                chk("readback_pc4", tb_mem[1], 32'h00100093);
            end
        end

        // Oversize length: ERR right after the second length byte, no writes.
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        chk("big_error", 32'(error), 32'd1);
        chk("big_done", 32'(done), 32'd0);
        chk("big_busy", 32'(busy), 32'd0);
        chk("big_hold", 32'(cpu_hold), 32'd1);
        rx_valid = 1'b1;
        repeat (4) begin
            rx_data = 8'($urandom);
            @(posedge clk);
            #1;
            chk("big_ready", 32'(rx_ready), 32'd0);
        end
        rx_valid = 1'b0;
        $display("session oversize: N=257 done=%0b error=%0b", done, error);

        // Reset in the middle of word 1 of a three-word load.
        do_start();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) exp_q.push_back('{addr: 32'h0, data: 32'h00000013});
            send_byte(v3.words[0][8*b +: 8], 0);
        end
        send_byte(v3.words[1][7:0], 0);
        send_byte(v3.words[1][15:8], 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(rx_ready), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_wdata", mem_wdata, 32'd0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_error", 32'(error), 32'd0);
        chk("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        chk("mid_rst_word0", tb_mem[0], 32'h00000013);
        $display("session reset: aborted during word 1");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fresh load after reset, with start pulses inside the session.
        run_image(v3, 6, 1'b1);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
